// File: rtl/uart_rx_if.sv
// Serial-line and received-byte signals of the 8N1 receiver.
interface uart_rx_if;
  logic       i_RxD;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic       o_Frame_Err;
  logic       o_Busy;

  modport master (
    input  i_RxD,
    output o_Data,
    output o_Valid,
    output o_Frame_Err,
    output o_Busy
  );

  modport slave (
    output i_RxD,
    input  o_Data,
    input  o_Valid,
    input  o_Frame_Err,
    input  o_Busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised line, single mid-bit sample, one-cycle o_Valid / o_Frame_Err strobes.
// Strobe ~2 + HALF_BIT + 9*CLKS_PER_BIT cycles after the start edge; no backpressure, the consumer must take each strobe.
module uart_rx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic      i_Clk,
  input  logic      i_Rst_n,
  uart_rx_if.master u_if
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TC = CW'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rx_meta;
  logic          r_rx_s;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_armed;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;

  logic          w_cnt_clr;
  logic          w_shift_en;
  logic          w_stop_ok;
  logic          w_stop_bad;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (r_armed && !r_rx_s) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        // A line that is high again at mid-start was a glitch, not a frame.
        if (r_cnt == HALF_TC) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_TC) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        // Leave at mid-stop so a start edge half a bit later is still caught.
        if (r_cnt == BIT_TC) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_IDLE;
          w_stop_ok   = r_rx_s;
          w_stop_bad  = !r_rx_s;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_armed   <= 1'b0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rx_meta <= u_if.i_RxD;
      r_rx_s    <= r_rx_meta;
      r_cnt     <= w_cnt_clr ? '0 : r_cnt + CW'(1);

      if (r_state == S_START) begin
        r_bit_idx <= 3'd0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      if (w_shift_en) begin
        r_shift <= {r_rx_s, r_shift[7:1]};
      end

      // A break (stop bit low) must release before the next frame can start.
      if (w_stop_bad) begin
        r_armed <= 1'b0;
      end else if (r_state == S_IDLE && r_rx_s) begin
        r_armed <= 1'b1;
      end

      r_valid <= w_stop_ok;
      r_ferr  <= w_stop_bad;
      if (w_stop_ok) begin
        r_data <= r_shift;
      end
    end
  end

  assign u_if.o_Data      = r_data;
  assign u_if.o_Valid     = r_valid;
  assign u_if.o_Frame_Err = r_ferr;
  assign u_if.o_Busy      = (r_state != S_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of the existing tx_2 transmitter.
- Samples the asynchronous serial line i_RxD, reconstructs bytes sent LSB-first, and presents each byte with a one-cycle valid strobe.
- Flags framing errors.
- Sits at the board pin on the same single clock as the transmitter path. It is used for loopback checking of the tx path and for host-to-board commands.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per bit period (100 MHz / 9600 baud). Legal range is 4 or more.
- HALF_BIT, CLKS_PER_BIT/2 (integer floor), cycles from start-edge detection to the start-bit mid-sample. Derived; not overridden.

Ports:
- i_Clk  input  1  system clock; all logic on rising edge
- i_Rst_n  input  1  asynchronous, active-low reset
- i_RxD  input  1  serial line, asynchronous to i_Clk, idles high
- o_Data  output  8  last correctly framed byte; held until the next good byte
- o_Valid  output  1  one-cycle pulse when o_Data is updated
- o_Frame_Err  output  1  one-cycle pulse when the stop bit samples low
- o_Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, i_Rst_n=0):
  - State is IDLE.
  - o_Data=8'h00, o_Valid=0, o_Frame_Err=0, o_Busy=0.
  - Bit counter and cycle counter are 0.
  - Both synchronizer flops are 1.
  - Reset mid-frame abandons the frame with no strobe. After release, the receiver waits for the line to be high before arming.
- Synchronizer: i_RxD passes through 2 flops. Only the synchronized signal rx_s is used; the raw pin is never used.
- IDLE:
  - Armed when rx_s=1.
  - When armed and rx_s=0, load cycle counter to 0 and go to START.
  - Not armed only after reset release or after a frame error, until rx_s is seen high.
- START:
  - Count to HALF_BIT-1.
  - On that cycle, if rx_s=0, go to DATA with counter=0 and bit index=0.
  - If rx_s=1, treat it as a glitch/false start and return to IDLE with no strobe.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into the shift register. Shift right; the new bit enters bit 7, so bit 0 is received first. Counter resets.
  - After the 8th sample (bit index 7), go to STOP.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - If 1: o_Data <= shift register and o_Valid=1 for exactly that one cycle.
  - If 0: o_Frame_Err=1 for one cycle, o_Data is unchanged, and arming is cleared (line break must release before re-arming).
  - Either way, go to IDLE on the next cycle.
  - No wait for the end of the stop bit. A start edge arriving half a bit later is caught.
- Latency: the o_Valid/o_Frame_Err strobe occurs 2 + HALF_BIT + 9*CLKS_PER_BIT cycles (±1 for edge phase) after the falling start edge on i_RxD.
- o_Valid and o_Frame_Err are never high together. Neither is high while state is IDLE entering from reset.
- Counters are sized as clog2(CLKS_PER_BIT) bits and never wrap. Each compare-and-reset occurs on the terminal count.
- Line activity during DATA/STOP other than at the sample instants is ignored. There is no majority voting; single mid-bit sample.
- Back-to-back frames with a 1-bit stop and no idle gap must be received without loss.

Test Plan (CLKS_PER_BIT=16 unless noted):
- Drive the 8N1 frame for 8'h61 -> exactly one o_Valid pulse at 2+8+144 ±1 cycles after the start edge, o_Data=8'h61, o_Frame_Err never high, o_Busy falls after the strobe.
- Drive 8'h55 then 8'hAA back-to-back with no idle gap -> two o_Valid pulses 160 ±1 cycles apart, o_Data=8'h55 then 8'hAA.
- Low glitch of 4 cycles on idle line -> START entered, returns to IDLE at the mid-sample, no o_Valid or o_Frame_Err, o_Data unchanged.
- Frame 8'h3C with stop bit driven 0, line held low 40 more cycles, then high, then frame 8'h12 -> one o_Frame_Err pulse, o_Data stays at its prior value, no spurious start during the low hold, then o_Valid with o_Data=8'h12.
- Assert i_Rst_n=0 for 3 cycles during DATA bit 4 of 8'hF0 -> outputs go to reset values immediately (asynchronous), no strobe for the remainder. The next full frame 8'h0F gives o_Data=8'h0F.
- CLKS_PER_BIT=5 (odd, HALF_BIT=2), frame 8'hA5 -> o_Valid with o_Data=8'hA5.
